mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store sequencer directly upstream of the word-organised 4 KB data memory (1024 x 32, word write only, combinational read).
- Accepts one load/store request at a time from the execute stage and drives the memory's word address, write data and write enable.
- Byte/halfword stores are done as read-modify-write, since the memory has no byte enables.
- Byte/halfword loads are sign- or zero-extended, and the result is returned with a one-cycle done pulse.

Parameters:
- ADDR_LSB, 2, lowest address bit sent to memory (word granularity).
- ADDR_MSB, 11, highest address bit sent to memory (4 KB window).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  1  request strobe; sampled only when ready=1
- op  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
- addr  input  32  byte address; bits 31:12 ignored
- wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse when the operation completes
- rdata  output  32  load result, valid while done=1, held until the next done
- addr_err  output  1  misalignment flag, valid with done (feature only; else tied 0)
- dm_addr  output  10  word address to memory, = addr_q[11:2]
- dm_din  output  32  write data to memory
- dm_we  output  1  memory write enable; memory writes at the same posedge
- dm_dout  input  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, ready=1, done=0, rdata=0, addr_err=0, dm_we=0, dm_din=0, addr_q/op_q/wdata_q/merge_q=0 (so dm_addr=0).
- Byte lanes (little-endian):
  - byte k = word[8k+7:8k], k=addr[1:0].
  - Halfword addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- State IDLE:
  - ready=1.
  - req=1: latch addr, op, wdata into addr_q/op_q/wdata_q, go to ACCESS.
  - req=0: stay.
- State ACCESS (dm_addr=addr_q[11:2]):
  - Loads: extract lane from dm_dout; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Register into rdata; go to RESP.
  - SW: dm_we=1, dm_din=wdata_q; go to RESP.
  - SB/SH: merge_q = dm_dout with the selected lane replaced by wdata_q[7:0]/[15:0]; go to MERGE.
- State MERGE: dm_we=1, dm_din=merge_q; go to RESP.
- State RESP: done=1; go to IDLE.
- Latency from accept edge to done=1:
  - loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: ready rises the cycle after done, so one request per 3 (or 4) cycles.
- dm_we is high only in ACCESS with SW, or in MERGE. dm_din=0 otherwise.
- req while ready=0 is ignored. Requester must hold req until it sees ready=1.
- rst mid-operation: return to IDLE next edge.
  - A write already committed at an earlier edge stays in memory.
  - A pending MERGE write is abandoned; memory is unchanged by that SB/SH.
- Without the feature, misaligned addresses are silently aligned: LH/LHU/SH ignore addr[0], LW/SW ignore addr[1:0].
- rdata changes only on the edge into RESP for loads. Stores leave rdata unchanged.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned request goes IDLE->RESP directly; dm_we is never asserted.
  - done=1 with addr_err=1; rdata is loaded with 0 for loads.
  - Latency is 1 cycle.
  - addr_err=0 on all aligned completions and whenever done=0.
- Without the macro: addr_err is constant 0 and alignment follows the Behaviour rules above.

Test Plan:
- Reset, then word memory[0x010>>2] = 0x8899AABB. LB addr=0x012 -> done 2 cycles after accept, rdata=0xFFFFFF99. LBU same addr -> rdata=0x00000099.
- LH addr=0x012 on the same word -> rdata=0xFFFF8899. LHU addr=0x010 -> rdata=0x0000AABB. LW -> rdata=0x8899AABB.
- SW addr=0x020 wdata=0x12345678, then SB addr=0x021 wdata=0xEE -> dm_we high exactly one cycle each. Final word 0x1234EE78; SB done at 3 cycles.
- SH addr=0x022 wdata=0xCAFE on word 0x1234EE78 -> word 0xCAFEEE78. req held high during busy -> exactly one store performed.
- SB in flight, rst asserted during MERGE -> dm_we low on that edge, word unchanged. ready=1 and done=0 the cycle after reset.
- Misaligned LW addr=0x023:
  - With MISALIGN_TRAP_EN: done 1 cycle later, addr_err=1, rdata=0, no dm_we.
  - Without it: reads the word at 0x020, addr_err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Load/store sequencer in front of a 1024 x 32 word-only data
//            memory with combinational read. Sub-word stores are performed as
//            read-modify-write; sub-word loads are sign/zero extended.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   req       : request strobe, accepted only while ready=1
//   op        : 000 LW 001 LB 010 LBU 011 LH 100 LHU 101 SW 110 SB 111 SH
//   addr      : byte address (only [ADDR_MSB:0] used)
//   wdata     : store data (SB uses [7:0], SH uses [15:0])
//   ready     : high in IDLE
//   done      : one-cycle completion pulse
//   rdata     : load result, held until the next load completes
//   addr_err  : misalignment flag, valid with done
//   dm_addr   : memory word address
//   dm_din    : memory write data (0 when not writing)
//   dm_we     : memory write enable
//   dm_dout   : memory combinational read data
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned LW/SW/LH/LHU/SH complete in
//                      one cycle with addr_err=1 instead of being aligned.
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_LSB = 2,
    parameter int ADDR_MSB = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic [2:0]                   op,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic                         ready,
    output logic                         done,
    output logic [31:0]                  rdata,
    output logic                         addr_err,
    output logic [ADDR_MSB-ADDR_LSB:0]   dm_addr,
    output logic [31:0]                  dm_din,
    output logic                         dm_we,
    input  logic [31:0]                  dm_dout
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_MSB:0]   addr_q,  addr_d;
    logic [2:0]          op_q,    op_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         merge_q, merge_d;
    logic [31:0]         rdata_q, rdata_d;

    // Address bits above the memory window are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_MSB+1];

    // Lane selection from the latched address (little-endian).
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign byte_sh      = {addr_q[1:0], 3'b000};
    assign half_sh      = {addr_q[1], 4'b0000};
    assign byte_shifted = dm_dout >> byte_sh;
    assign byte_lane    = byte_shifted[7:0];
    assign half_lane    = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

    always_comb begin
        load_val = dm_dout;
        case (op_q)
            OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_val = {24'h000000, byte_lane};
            OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_val = {16'h0000, half_lane};
            default: load_val = dm_dout;
        endcase
    end

    // Read-modify-write: clear the target lane, then OR in the new data.
    always_comb begin
        if (op_q == OP_SH) begin
            merge_val = (dm_dout & ~(32'h0000_FFFF << half_sh))
                      | ({16'h0000, wdata_q[15:0]} << half_sh);
        end else begin
            merge_val = (dm_dout & ~(32'h0000_00FF << byte_sh))
                      | ({24'h000000, wdata_q[7:0]} << byte_sh);
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;

    function automatic logic misaligned(input logic [2:0] o, input logic [1:0] a);
        case (o)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return (a != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

    assign addr_err = (state_q == S_RESP) && err_q;
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        ready   = 1'b0;
        done    = 1'b0;
        dm_we   = 1'b0;
        dm_din  = 32'h0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    addr_d  = addr[ADDR_MSB:0];
                    op_d    = op;
                    wdata_d = wdata;
                    state_d = S_ACCESS;
`ifdef MISALIGN_TRAP_EN
                    err_d = misaligned(op, addr[1:0]);
                    if (err_d) begin
                        state_d = S_RESP;
                        // Loads are opcodes 000..100.
                        if (op <= OP_LHU) rdata_d = 32'h0;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (op_q <= OP_LHU) begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end else if (op_q == OP_SW) begin
                    // A reset arriving now must not let the write land.
                    dm_we   = !rst;
                    dm_din  = wdata_q;
                    state_d = S_RESP;
                end else begin
                    merge_d = merge_val;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                dm_we   = !rst;
                dm_din  = merge_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rdata   = rdata_q;
    assign dm_addr = addr_q[ADDR_MSB:ADDR_LSB];

endmodule
`default_nettype wire
